// File: rtl/rle_pkg.sv
// Shared definitions for the parametrised run-length encoder.
// Holds the rle_mode encodings, the fixed mode limits, the encoder state enum
// and the helper that maps a disabled_groups vector onto the active width W.
package rle_pkg;

  // rle_mode encodings; 0 and 3 both select the full payload field limit
  localparam logic [1:0] RLE_MODE_MAX0 = 2'd0;
  localparam logic [1:0] RLE_MODE_255  = 2'd1;
  localparam logic [1:0] RLE_MODE_15   = 2'd2;
  localparam logic [1:0] RLE_MODE_MAX3 = 2'd3;

  localparam int unsigned RLE_LIMIT_255 = 255;
  localparam int unsigned RLE_LIMIT_15  = 15;

  // Widest disabled_groups vector the width helper accepts
  localparam int unsigned RLE_MAX_GROUPS = 64;

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_ENC   = 2'd1,
    ST_FLUSH = 2'd2
  } rle_state_e;

  // Active width W = GROUP_W * enabled groups; all disabled means full width
  function automatic int unsigned rle_active_width(
    input logic [RLE_MAX_GROUPS-1:0] dis,
    input int unsigned               num_groups,
    input int unsigned               group_w
  );
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < RLE_MAX_GROUPS; i++) begin
      if ((i < num_groups) && !dis[i]) n++;
    end
    if (n == 0) n = num_groups;
    return n * group_w;
  endfunction

endpackage

// File: rtl/rle_width_mask.sv
// Combinational width decoder for the run-length encoder.
// Ports:
//   i_disabled_groups  group disable vector (LSB-contiguous enabled groups)
//   i_rle_mode         run-length limit selection
//   o_payload_mask_c   ones on bits [W-2:0]
//   o_flag_bit_c       one-hot on bit W-1
//   o_limit_c          run-length limit L = min(mode limit, 2^(W-1)-1)
module rle_width_mask
  import rle_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned GROUP_W    = 8,
  parameter int unsigned NUM_GROUPS = DATA_W / GROUP_W
) (
  input  logic [NUM_GROUPS-1:0] i_disabled_groups,
  input  logic [1:0]            i_rle_mode,
  output logic [DATA_W-1:0]     o_payload_mask_c,
  output logic [DATA_W-1:0]     o_flag_bit_c,
  output logic [DATA_W-2:0]     o_limit_c
);

  localparam int unsigned CNT_W = DATA_W - 1;

  int unsigned w_width;

  // Mask, flag position and limit all follow from the active width
  always_comb begin
    w_width          = rle_active_width(RLE_MAX_GROUPS'(i_disabled_groups),
                                        NUM_GROUPS, GROUP_W);
    o_payload_mask_c = '0;
    o_flag_bit_c     = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if ((i + 1) < w_width)  o_payload_mask_c[i] = 1'b1;
      if ((i + 1) == w_width) o_flag_bit_c[i]     = 1'b1;
    end
    // The payload mask read as a number is the field maximum 2^(W-1)-1
    o_limit_c = o_payload_mask_c[CNT_W-1:0];
    // A fixed limit only applies when the field is wider than that limit
    case (i_rle_mode)
      RLE_MODE_255: if (w_width > 9) o_limit_c = CNT_W'(RLE_LIMIT_255);
      RLE_MODE_15:  if (w_width > 5) o_limit_c = CNT_W'(RLE_LIMIT_15);
      default:      ;
    endcase
  end

endmodule

// File: rtl/rle_enc_param.sv
// Parametrised run-length encoder for the capture path.
// Ports:
//   clock, reset       clock and synchronous active-low reset
//   enable             1 = RLE encoding, 0 = registered pass-through
//   rle_mode           run-length limit selection
//   disabled_groups    channel group disables (sets active width W)
//   data_in, valid_in  input sample and strobe
//   data_out, valid_out value/count word and strobe (1-cycle latency)
//   drop               sample discarded during the flush cycle
module rle_enc_param
  import rle_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned GROUP_W    = 8,
  parameter int unsigned NUM_GROUPS = DATA_W / GROUP_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            rle_mode,
  input  logic [NUM_GROUPS-1:0] disabled_groups,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  valid_in,
  output logic [DATA_W-1:0]     data_out,
  output logic                  valid_out,
  output logic                  drop
);

  localparam int unsigned CNT_W = DATA_W - 1;

  rle_state_e        r_state, w_nxt_state;
  logic [DATA_W-1:0] r_data_out, w_nxt_data;
  logic              r_valid_out, w_nxt_valid;
  logic              r_drop, w_nxt_drop;
  logic [CNT_W-1:0]  r_count, w_nxt_count;
  logic [CNT_W-1:0]  r_pend, w_nxt_pend;
  logic              r_pend_full, w_nxt_pend_full;
  logic [CNT_W-1:0]  r_last, w_nxt_last;
  logic              r_last_valid, w_nxt_last_valid;

  logic [DATA_W-1:0] w_payload_mask;
  logic [DATA_W-1:0] w_flag_bit;
  logic [CNT_W-1:0]  w_limit;
  logic [CNT_W-1:0]  w_sample;
  logic [CNT_W-1:0]  w_count_inc;

  rle_width_mask #(
    .DATA_W     (DATA_W),
    .GROUP_W    (GROUP_W),
    .NUM_GROUPS (NUM_GROUPS)
  ) u_width_mask (
    .i_disabled_groups (disabled_groups),
    .i_rle_mode        (rle_mode),
    .o_payload_mask_c  (w_payload_mask),
    .o_flag_bit_c      (w_flag_bit),
    .o_limit_c         (w_limit)
  );

  assign w_sample    = data_in[CNT_W-1:0] & w_payload_mask[CNT_W-1:0];
  assign w_count_inc = r_count + CNT_W'(1);

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_PASS;
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_drop       <= 1'b0;
      r_count      <= '0;
      r_pend       <= '0;
      r_pend_full  <= 1'b0;
      r_last       <= '0;
      r_last_valid <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_data_out   <= w_nxt_data;
      r_valid_out  <= w_nxt_valid;
      r_drop       <= w_nxt_drop;
      r_count      <= w_nxt_count;
      r_pend       <= w_nxt_pend;
      r_pend_full  <= w_nxt_pend_full;
      r_last       <= w_nxt_last;
      r_last_valid <= w_nxt_last_valid;
    end
  end

  // Next-state and output word selection.
  // PASS and FLUSH always hold cleared encoder state, so a sample arriving
  // with enable high in either of them takes the "no last value" path.
  // FLUSH only marks the cycle after the flush word and otherwise acts as PASS.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_data       = '0;
    w_nxt_valid      = 1'b0;
    w_nxt_drop       = 1'b0;
    w_nxt_count      = r_count;
    w_nxt_pend       = r_pend;
    w_nxt_pend_full  = r_pend_full;
    w_nxt_last       = r_last;
    w_nxt_last_valid = r_last_valid;

    if (enable) begin
      w_nxt_state = ST_ENC;
      if (valid_in) begin
        w_nxt_valid      = 1'b1;
        w_nxt_last       = w_sample;
        w_nxt_last_valid = 1'b1;
        if (!r_last_valid) begin
          w_nxt_data = DATA_W'(w_sample);
        end else if (w_sample != r_last) begin
          if (r_pend_full) begin
            w_nxt_data = DATA_W'(r_pend);
            w_nxt_pend = w_sample;
          end else if (r_count != '0) begin
            // Count word goes out now; the new value waits one step
            w_nxt_data      = w_flag_bit | DATA_W'(r_count);
            w_nxt_count     = '0;
            w_nxt_pend      = w_sample;
            w_nxt_pend_full = 1'b1;
          end else begin
            w_nxt_data = DATA_W'(w_sample);
          end
        end else if (r_pend_full) begin
          w_nxt_data      = DATA_W'(r_pend);
          w_nxt_pend_full = 1'b0;
          w_nxt_count     = CNT_W'(1);
        end else if (w_count_inc >= w_limit) begin
          // Saturated run: emit and restart; >= recovers from illegal mode changes
          w_nxt_data  = w_flag_bit | DATA_W'(w_count_inc);
          w_nxt_count = '0;
        end else begin
          w_nxt_valid = 1'b0;
          w_nxt_count = w_count_inc;
        end
      end
    end else if (r_state == ST_ENC) begin
      w_nxt_state = ST_FLUSH;
      if (r_pend_full) begin
        w_nxt_data  = DATA_W'(r_pend);
        w_nxt_valid = 1'b1;
      end else if (r_count != '0) begin
        w_nxt_data  = w_flag_bit | DATA_W'(r_count);
        w_nxt_valid = 1'b1;
      end
      w_nxt_drop       = valid_in;
      w_nxt_count      = '0;
      w_nxt_pend_full  = 1'b0;
      w_nxt_last_valid = 1'b0;
    end else begin
      w_nxt_state = ST_PASS;
      w_nxt_data  = data_in & (w_payload_mask | w_flag_bit);
      w_nxt_valid = valid_in;
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign drop      = r_drop;

endmodule
